// File: rtl/fft_axi_master_if.sv
// AXI-style burst channels between the FFT burst master and the FFT core slave port.
interface fft_axi_master_if;
  logic [11:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [1:0]  AWID;
  logic        AWVALID;
  logic        AWREADY;
  logic [15:0] WDATA;
  logic [1:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BID;
  logic        BVALID;
  logic        BREADY;
  logic [11:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [1:0]  ARID;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RID;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BVALID, output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID, input ARREADY,
    input  RDATA, RID, RLAST, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BVALID, input BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID, output ARREADY,
    output RDATA, RID, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/fft_axi_master.sv
// Burst master: streams samples into the FFT core with AW/W/B bursts, waits for
// completion, then reads results back with AR/R bursts onto a result stream.
module fft_axi_master #(
  parameter int unsigned MAX_BURST = 256,
  parameter logic [11:0] WR_BASE   = 12'h000,
  parameter logic [11:0] RD_BASE   = 12'h000,
  parameter logic [1:0]  TXN_ID    = 2'b01
) (
  input  logic        clk,
  input  logic        n_Reset,
  input  logic        start,
  input  logic [11:0] cfg_num,
  input  logic        cfg_mac,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        fft_done,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [11:0] SAMP_NUMBER,
  output logic        MAC_nRADIX,
  fft_axi_master_if.master axi
);

  localparam int unsigned AW = 12;
  localparam int unsigned BW = 9;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, WAIT_FFT, RD_ADDR, RD_DATA, DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   num_q, num_d;
  logic [AW-1:0]   samp_q, samp_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   rem_q, rem_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [7:0]      len_q, len_d;
  logic            mac_q, mac_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            awvalid_q, awvalid_d;
  logic            arvalid_q, arvalid_d;
  logic            bready_q, bready_d;
  logic            load_burst;
  logic            last_beat_c;
  logic            w_fire_c;
  logic            r_fire_c;

  // Data phases are pure passthrough, gated by state so reset silences them at once
  assign last_beat_c = (cnt_q == (beats_q - BW'(1)));
  assign axi.WVALID  = (state_q == WR_DATA) && s_valid;
  assign s_ready     = (state_q == WR_DATA) && axi.WREADY;
  assign axi.WDATA   = s_data;
  assign axi.WLAST   = (state_q == WR_DATA) && last_beat_c;
  assign axi.WSTRB   = 2'b11;
  assign w_fire_c    = axi.WVALID && axi.WREADY;

  assign m_valid     = (state_q == RD_DATA) && axi.RVALID;
  assign axi.RREADY  = (state_q == RD_DATA) && m_ready;
  assign m_data      = axi.RDATA;
  assign r_fire_c    = m_valid && axi.RREADY;

  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = len_q;
  assign axi.AWSIZE  = 3'd1;
  assign axi.AWBURST = 2'b01;
  assign axi.AWID    = TXN_ID;
  assign axi.AWVALID = awvalid_q;
  assign axi.BREADY  = bready_q;
  assign axi.ARADDR  = addr_q;
  assign axi.ARLEN   = len_q;
  assign axi.ARSIZE  = 3'd2;
  assign axi.ARBURST = 2'b01;
  assign axi.ARID    = TXN_ID;
  assign axi.ARVALID = arvalid_q;

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign SAMP_NUMBER = samp_q;
  assign MAC_nRADIX  = mac_q;

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    samp_d     = samp_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    beats_d    = beats_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    mac_d      = mac_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    awvalid_d  = awvalid_q;
    arvalid_d  = arvalid_q;
    bready_d   = bready_q;
    load_burst = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (cfg_num != AW'(0))) begin
          num_d      = cfg_num;
          samp_d     = cfg_num;
          mac_d      = cfg_mac;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          addr_d     = WR_BASE;
          rem_d      = cfg_num;
          load_burst = 1'b1;
          awvalid_d  = 1'b1;
          state_d    = WR_ADDR;
        end
      end
      WR_ADDR: begin
        if (axi.AWREADY) begin
          awvalid_d = 1'b0;
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (w_fire_c) begin
          cnt_d = cnt_q + BW'(1);
          if (last_beat_c) begin
            bready_d = 1'b1;
            state_d  = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (axi.BVALID) begin
          bready_d = 1'b0;
          if (axi.BID != TXN_ID) err_d = 1'b1;
          addr_d = addr_q + AW'({beats_q, 1'b0});
          rem_d  = rem_q - AW'(beats_q);
          if (rem_d != AW'(0)) begin
            load_burst = 1'b1;
            awvalid_d  = 1'b1;
            state_d    = WR_ADDR;
          end else begin
            state_d = WAIT_FFT;
          end
        end
      end
      WAIT_FFT: begin
        if (fft_done) begin
          addr_d     = RD_BASE;
          rem_d      = num_q;
          load_burst = 1'b1;
          arvalid_d  = 1'b1;
          state_d    = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (axi.ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        // The beat counter ends the burst; a misplaced RLAST only flags an error
        if (r_fire_c) begin
          cnt_d = cnt_q + BW'(1);
          if (axi.RID != TXN_ID) err_d = 1'b1;
          if (axi.RLAST != last_beat_c) err_d = 1'b1;
          if (last_beat_c) begin
            addr_d = addr_q + AW'({beats_q, 2'b00});
            rem_d  = rem_q - AW'(beats_q);
            if (rem_d != AW'(0)) begin
              load_burst = 1'b1;
              arvalid_d  = 1'b1;
              state_d    = RD_ADDR;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = DONE;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load_burst) begin
      beats_d = (rem_d > AW'(MAX_BURST)) ? BW'(MAX_BURST) : BW'(rem_d);
      len_d   = 8'(beats_d - BW'(1));
      cnt_d   = BW'(0);
    end
  end

  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      state_q   <= IDLE;
      num_q     <= '0;
      samp_q    <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      beats_q   <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      mac_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      samp_q    <= samp_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      beats_q   <= beats_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      mac_q     <= mac_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
    end
  end

endmodule
